sr_reg_writer: RTL and testbench
================================

SR_REG_WRITER -- requirements
Module: sr_reg_writer

Interface
REQ-001 Parameter WIDTH, default 4: number of SR flip-flop bits driven.
REQ-002 Parameter MAX_RETRY, default 2: re-drive attempts after a failed readback before the block flags an error.
REQ-003 clk  input  1  Single clock; every state change occurs on the rising edge.
REQ-004 rst_n  input  1  Asynchronous active-low reset.
REQ-005 wr_valid  input  1  Write request present.
REQ-006 wr_data  input  WIDTH  Target value for the SR register.
REQ-007 wr_ready  output  1  Block can accept a request.
REQ-008 s  output  WIDTH  Set drive to the per-bit SR flip-flops.
REQ-009 r  output  WIDTH  Reset drive to the per-bit SR flip-flops.
REQ-010 q  input  WIDTH  Readback of the SR flip-flop outputs.
REQ-011 done  output  1  One-cycle pulse when a write completes with a matching readback.
REQ-012 err  output  1  One-cycle pulse when a write fails after all retries.

Function
REQ-013 The FSM SHALL have four states: IDLE, DRIVE, SETTLE, CHECK.
REQ-014 wr_ready SHALL be 1 only in IDLE.
REQ-015 Handshake: a request is accepted when wr_valid=1 and wr_ready=1 on a clock edge.
REQ-016 On acceptance, wr_data SHALL be captured into an internal target register and q into a snapshot register, the retry count SHALL clear to 0, and the FSM SHALL go to DRIVE.
REQ-017 In DRIVE, s SHALL equal target & ~snapshot and r SHALL equal ~target & snapshot, both registered, for exactly one cycle.
REQ-018 s & r SHALL be 0 in every cycle and every state; driving S=R=1 (the forbidden SR input) SHALL never occur.
REQ-019 Bits whose target already equals the snapshot SHALL have s=r=0, giving the SR hold condition.
REQ-020 DRIVE SHALL always go to SETTLE; in SETTLE, s=r=0 for one cycle so that the master-slave flop's output has updated.
REQ-021 SETTLE SHALL always go to CHECK.
REQ-022 In CHECK, if q equals target, the block SHALL assert done for one cycle and return to IDLE.
REQ-023 In CHECK, on a mismatch with retry count < MAX_RETRY, the block SHALL increment the retry count, resnapshot q, and return to DRIVE.
REQ-024 In CHECK, on a mismatch with retry count = MAX_RETRY, the block SHALL assert err for one cycle and return to IDLE.
REQ-025 Best-case latency is 3 cycles from acceptance to done; worst case is 3*(MAX_RETRY+1) cycles to done or err.
REQ-026 done and err SHALL never both be 1 in the same cycle.
REQ-027 wr_valid and wr_data SHALL be ignored outside IDLE; a request held through a busy period is accepted on the first IDLE edge.
REQ-028 A target equal to the current q SHALL still traverse DRIVE/SETTLE/CHECK with s=r=0 and end in done.
REQ-029 The retry counter width SHALL hold MAX_RETRY without wrap-around.
REQ-030 Unused state encodings SHALL return to IDLE on the next edge.

Reset
REQ-031 rst_n=0 SHALL immediately and asynchronously force: state IDLE, s=0, r=0, done=0, err=0, wr_ready=1, target=0, snapshot=0, retry count=0.
REQ-032 Reset asserted mid-operation SHALL abort the write with no done or err pulse.
REQ-033 Release of rst_n SHALL take effect on the first following rising edge; a request present at that edge is accepted.

Verification
REQ-034 q=0000, write 1010 -> DRIVE cycle s=1010 r=0000; SETTLE s=r=0; model flop sets q=1010; done pulse 3 cycles after acceptance.
REQ-035 q=1100, write 0110 -> s=0010, r=1000 in DRIVE; done after q=0110; s&r=0 checked every cycle.
REQ-036 q=0101, write 0101 -> s=r=0000 throughout; done at cycle 3.
REQ-037 Flop model stuck with q[0]=0, write 0001 -> 3 DRIVE attempts; err pulse at cycle 9; no done pulse.
REQ-038 rst_n pulled low during SETTLE -> outputs return to reset values immediately; no done or err pulse; wr_ready=1.
REQ-039 wr_valid held high with new data while busy -> second request accepted only on the IDLE edge after the first done.

Source files
------------

// File: rtl/sr_reg_writer.sv
// Writes a target value into a bank of external master-slave SR flip-flops,
// driving only the bits that must change and verifying the readback with retries.
module sr_reg_writer #(
  parameter int WIDTH     = 4,
  parameter int MAX_RETRY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] q,
  output logic             done,
  output logic             err
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SETTLE = 2'd2,
    CHECK  = 2'd3
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] target_r, target_s;
  logic [WIDTH-1:0] snap_r, snap_s;
  logic [RW-1:0]    retry_r, retry_s;
  logic [WIDTH-1:0] set_r, set_s;
  logic [WIDTH-1:0] clr_r, clr_s;
  logic             done_r, done_s;
  logic             err_r, err_s;
  logic             ready_r, ready_s;

  assign s        = set_r;
  assign r        = clr_r;
  assign done     = done_r;
  assign err      = err_r;
  assign wr_ready = ready_r;

  // Next-state and next-output decode; set/clear are derived from one target and
  // one snapshot, so a bit can never be both set and cleared.
  always_comb begin
    state_s  = state_r;
    target_s = target_r;
    snap_s   = snap_r;
    retry_s  = retry_r;
    set_s    = {WIDTH{1'b0}};
    clr_s    = {WIDTH{1'b0}};
    done_s   = 1'b0;
    err_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (wr_valid && ready_r) begin
          target_s = wr_data;
          snap_s   = q;
          retry_s  = {RW{1'b0}};
          set_s    = wr_data & ~q;
          clr_s    = ~wr_data & q;
          state_s  = DRIVE;
        end else begin
          state_s  = IDLE;
        end
      end
      DRIVE:  state_s = SETTLE;
      SETTLE: state_s = CHECK;
      CHECK: begin
        if (q == target_r) begin
          done_s  = 1'b1;
          state_s = IDLE;
        end else if (retry_r < RW'(MAX_RETRY)) begin
          retry_s = retry_r + RW'(1);
          snap_s  = q;
          set_s   = target_r & ~q;
          clr_s   = ~target_r & q;
          state_s = DRIVE;
        end else begin
          err_s   = 1'b1;
          state_s = IDLE;
        end
      end
      default: state_s = IDLE;
    endcase
    ready_s = (state_s == IDLE);
  end

  // State, capture registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      target_r <= {WIDTH{1'b0}};
      snap_r   <= {WIDTH{1'b0}};
      retry_r  <= {RW{1'b0}};
      set_r    <= {WIDTH{1'b0}};
      clr_r    <= {WIDTH{1'b0}};
      done_r   <= 1'b0;
      err_r    <= 1'b0;
      ready_r  <= 1'b1;
    end else begin
      state_r  <= state_s;
      target_r <= target_s;
      snap_r   <= snap_s;
      retry_r  <= retry_s;
      set_r    <= set_s;
      clr_r    <= clr_s;
      done_r   <= done_s;
      err_r    <= err_s;
      ready_r  <= ready_s;
    end
  end

endmodule

// File: tb/tb_sr_reg_writer.sv
// Scoreboard bench for sr_reg_writer with a behavioural master-slave SR flop bank
// (optional stuck-at-0 bits) closing the readback loop.
module tb_sr_reg_writer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic [3:0] wr_data = 4'd0;
  logic       wr_ready;
  logic [3:0] s, r;
  logic [3:0] q_f = 4'd0;
  logic       done, err;

  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic [3:0] stuck = 4'd0;

  typedef struct {
    logic [3:0] es;
    logic [3:0] er;
    bit         is_err;
    int         lat;
  } exp_t;
  exp_t sb[$];

  int cyc = 0;
  int acc = -100;
  int n_chk = 0;
  int n_fail = 0;

  sr_reg_writer #(.WIDTH(4), .MAX_RETRY(2)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .s(s), .r(r), .q(q_f), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // SR flop bank: set wins where r=0, reset where s=0; stuck bits read 0.
  always @(posedge clk) begin
    if (load) q_f <= load_val;
    else      q_f <= ((q_f | s) & ~r) & ~stuck;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: checks every cycle, pops the scoreboard on done/err.
  always @(negedge clk) begin
    exp_t e;
    chk("s_and_r_zero", {28'd0, s & r}, 32'd0);
    if (done && err) chk("done_err_exclusive", 32'd1, 32'd0);
    if (done || err) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {31'd0, done}, {31'd0, err} ^ 32'd1 ^ {31'd0, done});
      end else begin
        e = sb.pop_front();
        chk("result_is_err", {31'd0, err}, {31'd0, e.is_err});
        chk("result_is_done", {31'd0, done}, {31'd0, !e.is_err});
        chk("latency", cyc - acc, e.lat);
      end
    end
    if (cyc == acc && sb.size() > 0) begin
      chk("drive_s", {28'd0, s}, {28'd0, sb[0].es});
      chk("drive_r", {28'd0, r}, {28'd0, sb[0].er});
    end
    if (rst_n && wr_valid && wr_ready) acc = cyc + 1;
  end

  task automatic preload(input logic [3:0] v);
    @(posedge clk); #2;
    load = 1'b1; load_val = v;
    @(posedge clk); #2;
    load = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] d, input logic [3:0] es, input logic [3:0] er,
                          input bit is_err, input int lat, input bit push);
    exp_t e;
    bit ok;
    e.es = es; e.er = er; e.is_err = is_err; e.lat = lat;
    if (push) sb.push_back(e);
    wr_data = d; wr_valid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wr_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #2;
    wr_valid = 1'b0;
    chk("accept_in_time", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && wr_ready) begin ok = 1'b1; break; end
    end
    chk("complete_in_time", {31'd0, ok}, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int busy;
    #12;
    chk("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
    chk("rst_s", {28'd0, s}, 32'd0);
    chk("rst_r", {28'd0, r}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // q=0000 -> 1010
    preload(4'b0000);
    do_write(4'b1010, 4'b1010, 4'b0000, 1'b0, 3, 1'b1);
    wait_idle();
    chk("q_after_1010", {28'd0, q_f}, 32'hA);

    // q=1100 -> 0110
    preload(4'b1100);
    do_write(4'b0110, 4'b0010, 4'b1000, 1'b0, 3, 1'b1);
    wait_idle();
    chk("q_after_0110", {28'd0, q_f}, 32'h6);

    // target already matches
    preload(4'b0101);
    do_write(4'b0101, 4'b0000, 4'b0000, 1'b0, 3, 1'b1);
    wait_idle();

    // stuck bit 0: three attempts then err
    preload(4'b0000);
    stuck = 4'b0001;
    do_write(4'b0001, 4'b0001, 4'b0000, 1'b1, 9, 1'b1);
    wait_idle();
    stuck = 4'b0000;

    // reset during SETTLE aborts; request present at release edge is accepted
    preload(4'b0000);
    do_write(4'b0011, 4'b0011, 4'b0000, 1'b0, 3, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("abort_s", {28'd0, s}, 32'd0);
    chk("abort_r", {28'd0, r}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_err", {31'd0, err}, 32'd0);
    chk("abort_wr_ready", {31'd0, wr_ready}, 32'd1);
    sb.push_back('{es: 4'b0100, er: 4'b0000, is_err: 1'b0, lat: 3});
    wr_data = 4'b0111; wr_valid = 1'b1;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_at_release", {31'd0, wr_ready}, 32'd1);
    @(posedge clk); #2;
    wr_valid = 1'b0;
    wait_idle();
    chk("q_after_release", {28'd0, q_f}, 32'h7);

    // request held with new data while busy
    preload(4'b0000);
    do_write(4'b0011, 4'b0011, 4'b0000, 1'b0, 3, 1'b1);
    wr_data = 4'b1111; wr_valid = 1'b1;
    sb.push_back('{es: 4'b1100, er: 4'b0000, is_err: 1'b0, lat: 3});
    busy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wr_ready) break;
      busy++;
    end
    chk("busy_cycles", busy, 3);
    chk("done_at_first_idle", {31'd0, done}, 32'd1);
    @(posedge clk); #2;
    wr_valid = 1'b0;
    wait_idle();
    chk("q_after_held", {28'd0, q_f}, 32'hF);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
